// File: rtl/gin_xy_bus.sv
// rtl/gin_xy_bus.sv - two-level (row/column) tagged multicast input network
//
// Purpose: stages one tagged word and multicasts it to every PE whose scanned
// row ID and column ID match the word's tags, only when all matched PEs are
// ready. A word that matches no PE is consumed with a one-cycle drop_pulse.
//
// Ports:
//   clk, rstb          clock, asynchronous active-low reset
//   program_i          scan-chain shift enable (stalls delivery and intake)
//   scan_tag_in        scan word entering chain index 0
//   in_valid/in_ready  source handshake
//   in_row_tag/in_col_tag/in_data  source word
//   target_ready       per-PE ready, PE p = r*NUM_COLS+c
//   target_enable      per-PE write strobe
//   output_value       per-PE data, slice p = [p*BITWIDTH +: BITWIDTH]
//   drop_pulse         staged word matched no PE
module gin_xy_bus #(
   parameter int BITWIDTH   = 16,
   parameter int TAG_LENGTH = 4,
   parameter int NUM_ROWS   = 3,
   parameter int NUM_COLS   = 4,
   parameter int BCAST_EN   = 1
) (
   input  logic                                     clk,
   input  logic                                     rstb,
   input  logic                                     program_i,
   input  logic [TAG_LENGTH-1:0]                    scan_tag_in,
   input  logic                                     in_valid,
   output logic                                     in_ready,
   input  logic [TAG_LENGTH-1:0]                    in_row_tag,
   input  logic [TAG_LENGTH-1:0]                    in_col_tag,
   input  logic [BITWIDTH-1:0]                      in_data,
   input  logic [NUM_ROWS*NUM_COLS-1:0]             target_ready,
   output logic [NUM_ROWS*NUM_COLS-1:0]             target_enable,
   output logic [BITWIDTH*NUM_ROWS*NUM_COLS-1:0]    output_value,
   output logic                                     drop_pulse
);

   localparam int NUM_PE    = NUM_ROWS * NUM_COLS;
   localparam int CHAIN_LEN = NUM_ROWS + NUM_PE;

   // Chain index 0..NUM_ROWS-1 holds row IDs, the rest hold column IDs in PE order.
   logic [CHAIN_LEN-1:0][TAG_LENGTH-1:0] ids_q, ids_d;

   logic                  buf_valid_q, buf_valid_d;
   logic [TAG_LENGTH-1:0] buf_row_q, buf_row_d;
   logic [TAG_LENGTH-1:0] buf_col_q, buf_col_d;
   logic [BITWIDTH-1:0]   buf_data_q, buf_data_d;

   logic [NUM_PE-1:0] match;
   logic              row_bcast;
   logic              col_bcast;
   logic              all_ready;
   logic              deliver;

   assign row_bcast = (BCAST_EN != 0) && (buf_row_q == {TAG_LENGTH{1'b1}});
   assign col_bcast = (BCAST_EN != 0) && (buf_col_q == {TAG_LENGTH{1'b1}});

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      logic row_hit;
      assign row_hit = (ids_q[r] == buf_row_q) || row_bcast;
      for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
         localparam int P = r * NUM_COLS + c;
         assign match[P] = buf_valid_q && row_hit &&
                           ((ids_q[NUM_ROWS + P] == buf_col_q) || col_bcast);
      end
   end

   // All-or-nothing: one unready matched PE blocks the whole multicast.
   assign all_ready = &(~match | target_ready);
   assign deliver   = buf_valid_q && !program_i && all_ready;

   assign target_enable = {NUM_PE{deliver}} & match;
   assign drop_pulse    = deliver && (match == '0);
   assign in_ready      = !program_i && (!buf_valid_q || deliver);

   for (genvar p = 0; p < NUM_PE; p++) begin : g_out
      assign output_value[p*BITWIDTH +: BITWIDTH] = target_enable[p] ? buf_data_q : '0;
   end

   always_comb begin
      ids_d       = ids_q;
      buf_valid_d = buf_valid_q;
      buf_row_d   = buf_row_q;
      buf_col_d   = buf_col_q;
      buf_data_d  = buf_data_q;
      if (program_i) begin
         ids_d = {ids_q[CHAIN_LEN-2:0], scan_tag_in};
      end
      if (in_valid && in_ready) begin
         buf_valid_d = 1'b1;
         buf_row_d   = in_row_tag;
         buf_col_d   = in_col_tag;
         buf_data_d  = in_data;
      end else if (deliver) begin
         buf_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         ids_q       <= '0;
         buf_valid_q <= 1'b0;
         buf_row_q   <= '0;
         buf_col_q   <= '0;
         buf_data_q  <= '0;
      end else begin
         ids_q       <= ids_d;
         buf_valid_q <= buf_valid_d;
         buf_row_q   <= buf_row_d;
         buf_col_q   <= buf_col_d;
         buf_data_q  <= buf_data_d;
      end
   end

endmodule
